// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding for the parallel-in serial-out transmitter and its bench.
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_e;
endpackage

// File: rtl/piso_if.sv
// piso_if: parallel word handshake in, serial bit handshake out.
interface piso_if #(parameter int width_p = 5);
  logic valid_i, ready_o, valid_o, data_o, ready_i, last_o;
  logic [width_p-1:0] data_i;
  modport master(output valid_i, data_i, ready_i, input ready_o, valid_o, data_o, last_o);
  modport slave(input valid_i, data_i, ready_i, output ready_o, valid_o, data_o, last_o);
endinterface

// File: rtl/piso_ctrl.sv
// piso_ctrl: word FSM and bit counter; PISO_PARITY_EN adds a trailing even-parity beat.
module piso_ctrl import piso_pkg::*; #(parameter int width_p = 5) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic valid_i,
  input  logic ready_i,
  output logic load,
  output logic shift_en,
  output logic par_sel,
  output logic valid_o,
  output logic ready_o,
  output logic last_o
);
  localparam int cw = $clog2(width_p);
  localparam logic [cw-1:0] last_cnt = cw'(width_p - 1);
  piso_state_e state, state_n;
  logic [cw-1:0] count, count_n;
  logic armed, at_last;
  // armed keeps ready_o low until the first edge after reset release
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state <= IDLE;
      count <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      armed <= 1'b1;
    end
  always_comb begin
    ready_o = armed && state == IDLE;
    valid_o = state != IDLE;
    par_sel = state == PARITY;
    load = ready_o && valid_i;
    shift_en = state == SHIFT && ready_i;
    at_last = state == SHIFT && count == last_cnt;
    count_n = load ? '0 : (shift_en && !at_last) ? count + 1'b1 : count;
`ifdef PISO_PARITY_EN
    last_o = par_sel;
    state_n = load ? SHIFT : (shift_en && at_last) ? PARITY : (par_sel && ready_i) ? IDLE : state;
`else
    last_o = at_last;
    state_n = load ? SHIFT : (shift_en && at_last) ? IDLE : state;
`endif
  end
endmodule

// File: rtl/piso_dff.sv
// piso_dff: enabled flop with per-instance reset value, one per shift register bit.
module piso_dff #(parameter logic reset_val = 1'b0) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) q <= reset_val;
    else if (en) q <= d;
endmodule

// File: rtl/piso.sv
// piso: parallel-in serial-out shifter, MSB first, one bit per accepted beat.
// Optional trailing even-parity beat when PISO_PARITY_EN is defined.
module piso import piso_pkg::*; #(
  parameter int width_p = 5,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input logic clk_i,
  input logic reset_ni,
  piso_if.slave bus
);
  logic load, shift_en, par_sel, parity;
  logic [width_p-1:0] shreg, shin;
  piso_ctrl #(.width_p(width_p)) u_ctrl (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .valid_i(bus.valid_i),
    .ready_i(bus.ready_i),
    .load(load),
    .shift_en(shift_en),
    .par_sel(par_sel),
    .valid_o(bus.valid_o),
    .ready_o(bus.ready_o),
    .last_o(bus.last_o)
  );
  assign shin = {shreg[width_p-2:0], 1'b0};
  for (genvar i = 0; i < width_p; i++) begin : g_bit
    piso_dff #(.reset_val(reset_val_p[i])) u_dff (
      .clk_i(clk_i),
      .reset_ni(reset_ni),
      .en(load | shift_en),
      .d(load ? bus.data_i[i] : shin[i]),
      .q(shreg[i])
    );
  end
`ifdef PISO_PARITY_EN
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) parity <= 1'b0;
    else if (load) parity <= ^bus.data_i;
`else
  assign parity = 1'b0;
`endif
  // serial bit is forced low whenever no beat is offered
  assign bus.data_o = bus.valid_o & (par_sel ? parity : shreg[width_p-1]);
endmodule

// File: tb/tb_piso.sv
// tb_piso: table-driven words plus stall and mid-word reset sequences, checked by a beat scoreboard.
`timescale 1ns/1ps
module tb_piso;
  import piso_pkg::*;
  localparam int w = 5;
`ifdef PISO_PARITY_EN
  localparam bit par = 1'b1;
`else
  localparam bit par = 1'b0;
`endif
  typedef struct { logic [w-1:0] word; logic [w-1:0] bits; logic pbit; } vec_t;
  typedef struct { logic d; logic l; } beat_t;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  int compared = 0;
  int mismatched = 0;
  beat_t exp_q[$];
  logic [w-1:0] rx = '0;
  vec_t vecs[6];
  piso_if #(.width_p(w)) bus();
  piso #(.width_p(w)) dut (.clk_i(clk_i), .reset_ni(reset_ni), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // receiver model: shift block fed by data_o, enabled by valid_o & ready_i, data beats only
  always @(posedge clk_i)
    if (bus.valid_o && bus.ready_i && !(par && bus.last_o)) rx <= {rx[w-2:0], bus.data_o};
  always @(negedge clk_i)
    if (reset_ni && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL extra_beat: got data_o=%0b with no beat expected at %0t", bus.data_o, $time);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data_o", bus.data_o, e.d);
        check("beat_last_o", bus.last_o, e.l);
      end
    end
  task automatic push_word(input vec_t v);
    for (int i = w - 1; i >= 0; i--) exp_q.push_back('{v.bits[i], !par && i == 0});
    if (par) exp_q.push_back('{v.pbit, 1'b1});
  endtask
  task automatic accept(input vec_t v);
    for (int t = 0; t < 20 && !bus.ready_o; t++) begin
      @(negedge clk_i);
      #1;
    end
    check("ready_o_before_accept", bus.ready_o, 1);
    bus.data_i = v.word;
    bus.valid_i = 1'b1;
    push_word(v);
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
    bus.data_i = w'($urandom);
    @(negedge clk_i);
    #1;
    check("valid_o_after_accept", bus.valid_o, 1);
    check("ready_o_busy", bus.ready_o, 0);
  endtask
  task automatic send(input vec_t v, input int stall_at, input int stall_len);
    int n = 0;
    int st = 0;
    accept(v);
    for (int c = 0; c < 4 * w + 20 && exp_q.size() > 0; c++) begin
      if (!bus.ready_i) begin
        check("stall_valid_o", bus.valid_o, 1);
        check("stall_data_o", bus.data_o, exp_q[0].d);
        check("stall_last_o", bus.last_o, exp_q[0].l);
      end else if (bus.valid_o) n++;
      @(posedge clk_i);
      #1;
      bus.ready_i = !(n == stall_at && st < stall_len);
      if (!bus.ready_i) st++;
      @(negedge clk_i);
      #1;
    end
    check("beats_left", exp_q.size(), 0);
    @(negedge clk_i);
    #1;
    check("bubble_ready_o", bus.ready_o, 1);
    check("bubble_valid_o", bus.valid_o, 0);
    check("bubble_data_o", bus.data_o, 0);
    check("loopback_word", rx, v.bits);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{5'b10110, 5'b10110, 1'b1};
    vecs[1] = '{5'b00001, 5'b00001, 1'b1};
    vecs[2] = '{5'b11111, 5'b11111, 1'b1};
    vecs[3] = '{5'b00000, 5'b00000, 1'b0};
    vecs[4] = '{5'b10101, 5'b10101, 1'b1};
    vecs[5] = '{5'b01100, 5'b01100, 1'b0};
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    bus.ready_i = 1'b1;
    #2;
    check("reset_valid_o", bus.valid_o, 0);
    check("reset_last_o", bus.last_o, 0);
    check("reset_ready_o", bus.ready_o, 0);
    @(negedge clk_i);
    #1;
    reset_ni = 1'b1;
    check("release_ready_o_before_edge", bus.ready_o, 0);
    @(negedge clk_i);
    #1;
    check("release_ready_o", bus.ready_o, 1);
    check("idle_valid_o", bus.valid_o, 0);
    check("idle_data_o", bus.data_o, 0);
    for (int k = 0; k < 6; k++) send(vecs[k], -1, 0);
    send(vecs[0], 2, 3);
    accept(vecs[2]);
    repeat (2) @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    check("midword_reset_valid_o", bus.valid_o, 0);
    check("midword_reset_last_o", bus.last_o, 0);
    check("midword_reset_ready_o", bus.ready_o, 0);
    check("midword_beats_taken", exp_q.size(), par ? 4 : 3);
    exp_q.delete();
    @(negedge clk_i);
    #1;
    reset_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      #1;
      check("post_reset_valid_o", bus.valid_o, 0);
    end
    send(vecs[1], -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
